// File: rtl/wash_ctrl_param.sv
// wash_ctrl_param: parametrised laundry-cycle controller, IDLE -> READY -> SOAK -> WASH -> RINSE -> SPIN.
// Lid-pause support is compiled in when LID_PAUSE_EN is defined; otherwise i_lid_open is ignored.
module wash_ctrl_param #(
    parameter int unsigned        TICKS_PER_SEC = 250,
    parameter int unsigned        MIN_W         = 8,
    parameter logic [4*MIN_W-1:0] SOAK_MIN      = {8'd5, 8'd3, 8'd15, 8'd5},
    parameter logic [4*MIN_W-1:0] WASH_MIN      = {8'd10, 8'd8, 8'd20, 8'd10},
    parameter logic [4*MIN_W-1:0] RINSE_MIN     = {8'd5, 8'd3, 8'd15, 8'd5},
    parameter logic [4*MIN_W-1:0] SPIN_MIN      = {8'd5, 8'd3, 8'd15, 8'd5},
    parameter int unsigned        COINS_REQ     = 1,
    localparam int unsigned       REM_W         = MIN_W + 6
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_coin,
    input  logic             i_start,
    input  logic             i_cancel,
    input  logic [1:0]       i_mode,
    input  logic             i_lid_open,
    output logic [5:0]       o_state,
    output logic [1:0]       o_mode,
    output logic [REM_W-1:0] o_rem_sec,
    output logic             o_done,
    output logic             o_paused
);
    localparam int unsigned      PRE_W     = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PRE_W-1:0] PRE_TOP   = PRE_W'(TICKS_PER_SEC - 1);
    localparam logic [3:0]       COINS_TOP = 4'(COINS_REQ);

    typedef enum logic [5:0] {
        S_IDLE  = 6'b000001,
        S_READY = 6'b000010,
        S_SOAK  = 6'b000100,
        S_WASH  = 6'b001000,
        S_RINSE = 6'b010000,
        S_SPIN  = 6'b100000
    } state_e;

    state_e           state_q, state_d;
    logic [1:0]       mode_q, mode_d;
    logic [REM_W-1:0] rem_q, rem_d;
    logic [PRE_W-1:0] presc_q, presc_d;
    logic [3:0]       coins_q, coins_d;
    logic             done_q, done_d;
    logic             in_phase, strobe, phase_end, paused, start_ok;

    // Minutes are widened before the multiply so 255 min * 60 still fits.
    function automatic logic [REM_W-1:0] to_sec(input logic [4*MIN_W-1:0] tbl, input logic [1:0] m);
        logic [MIN_W-1:0] mins;
        mins = tbl[int'(m)*MIN_W +: MIN_W];
        return REM_W'(mins) * REM_W'(60);
    endfunction

    assign in_phase  = (state_q == S_SOAK) || (state_q == S_WASH) ||
                       (state_q == S_RINSE) || (state_q == S_SPIN);
    assign strobe    = (presc_q == PRE_TOP);
    assign phase_end = (rem_q == '0) || (strobe && (rem_q == REM_W'(1)));

`ifdef LID_PAUSE_EN
    assign paused   = in_phase && i_lid_open;
    assign start_ok = i_start && !i_lid_open;
`else
    logic unused_lid;
    assign unused_lid = i_lid_open;
    assign paused     = 1'b0;
    assign start_ok   = i_start;
`endif

    always_comb begin
        // NOTE: every _d gets a hold default first so no path through the ifs can infer a latch.
        state_d = state_q;
        mode_d  = mode_q;
        rem_d   = rem_q;
        presc_d = presc_q;
        coins_d = coins_q;
        done_d  = 1'b0;
        if (i_cancel) begin
            state_d = S_IDLE;
            coins_d = '0;
            rem_d   = '0;
            presc_d = '0;
        end else if (in_phase && !paused) begin
            if (phase_end) begin
                presc_d = '0;
                case (state_q)
                    S_SOAK:  begin state_d = S_WASH;  rem_d = to_sec(WASH_MIN, mode_q);  end
                    S_WASH:  begin state_d = S_RINSE; rem_d = to_sec(RINSE_MIN, mode_q); end
                    S_RINSE: begin state_d = S_SPIN;  rem_d = to_sec(SPIN_MIN, mode_q);  end
                    default: begin
                        state_d = S_IDLE;
                        rem_d   = '0;
                        coins_d = '0;
                        done_d  = 1'b1;
                    end
                endcase
            end else begin
                presc_d = strobe ? '0 : presc_q + PRE_W'(1);
                if (strobe) rem_d = rem_q - REM_W'(1);
            end
        end else if ((state_q == S_READY) && start_ok) begin
            state_d = S_SOAK;
            mode_d  = i_mode;
            rem_d   = to_sec(SOAK_MIN, i_mode);
            presc_d = '0;
        end else if ((state_q == S_IDLE) && i_coin) begin
            if (coins_q + 4'd1 >= COINS_TOP) begin
                coins_d = COINS_TOP;
                state_d = S_READY;
            end else begin
                coins_d = coins_q + 4'd1;
            end
        end
    end

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            mode_q  <= '0;
            rem_q   <= '0;
            presc_q <= '0;
            coins_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            rem_q   <= rem_d;
            presc_q <= presc_d;
            coins_q <= coins_d;
            done_q  <= done_d;
        end
    end

    assign o_state   = state_q;
    assign o_mode    = mode_q;
    assign o_rem_sec = rem_q;
    assign o_done    = done_q;
    assign o_paused  = paused;
endmodule

// File: tb/tb_wash_ctrl_param.sv
// Randomised bench for wash_ctrl_param against a phase-elapsed-time model (TICKS_PER_SEC=2, COINS_REQ=2).
module tb_wash_ctrl_param;
    localparam int T     = 2;
    localparam int CR    = 2;
    localparam int REM_W = 14;
`ifdef LID_PAUSE_EN
    localparam bit LID_EN = 1'b1;
`else
    localparam bit LID_EN = 1'b0;
`endif

    // Per-mode minutes: mode1 has a zero RINSE, mode3 zero SOAK and SPIN.
    int soak_min  [4] = '{1, 2, 3, 0};
    int wash_min  [4] = '{1, 1, 2, 1};
    int rinse_min [4] = '{1, 0, 1, 1};
    int spin_min  [4] = '{1, 1, 1, 0};

    logic             i_clk = 1'b0, i_rst_n = 1'b0;
    logic             i_coin = 1'b0, i_start = 1'b0, i_cancel = 1'b0, i_lid_open = 1'b0;
    logic [1:0]       i_mode = 2'd0;
    logic [5:0]       o_state;
    logic [1:0]       o_mode;
    logic [REM_W-1:0] o_rem_sec;
    logic             o_done, o_paused;

    wash_ctrl_param #(
        .TICKS_PER_SEC(T), .MIN_W(8),
        .SOAK_MIN ({8'd0, 8'd3, 8'd2, 8'd1}),
        .WASH_MIN ({8'd1, 8'd2, 8'd1, 8'd1}),
        .RINSE_MIN({8'd1, 8'd1, 8'd0, 8'd1}),
        .SPIN_MIN ({8'd0, 8'd1, 8'd1, 8'd1}),
        .COINS_REQ(CR)
    ) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_coin(i_coin), .i_start(i_start),
        .i_cancel(i_cancel), .i_mode(i_mode), .i_lid_open(i_lid_open),
        .o_state(o_state), .o_mode(o_mode), .o_rem_sec(o_rem_sec),
        .o_done(o_done), .o_paused(o_paused)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0, n_errors = 0;
    int m_st, m_mode, m_coins, m_elapsed;   // m_st: 0 IDLE .. 5 SPIN
    bit m_done, cur_lid;
    int lid_left = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int phase_min(input int st, input int md);
        case (st)
            2: return soak_min[md];
            3: return wash_min[md];
            4: return rinse_min[md];
            5: return spin_min[md];
            default: return 0;
        endcase
    endfunction

    function automatic int phase_len(input int st);
        int n;
        n = phase_min(st, m_mode) * 60 * T;
        return (n == 0) ? 1 : n;
    endfunction

    function automatic int exp_rem();
        return (m_st >= 2) ? phase_min(m_st, m_mode) * 60 - m_elapsed / T : 0;
    endfunction

    task automatic model_reset();
        m_st = 0; m_mode = 0; m_coins = 0; m_elapsed = 0; m_done = 1'b0;
    endtask

    task automatic model_step(input bit coin, input bit start, input bit cancel, input int md, input bit lid);
        bit paused;
        paused = LID_EN && lid && (m_st >= 2);
        m_done = 1'b0;
        if (cancel) begin
            m_st = 0; m_coins = 0; m_elapsed = 0;
        end else if (m_st >= 2 && !paused) begin
            m_elapsed++;
            if (m_elapsed >= phase_len(m_st)) begin
                m_elapsed = 0;
                if (m_st == 5) begin
                    m_st = 0; m_coins = 0; m_done = 1'b1;
                end else begin
                    m_st++;
                end
            end
        end else if (m_st == 1 && start && !(LID_EN && lid)) begin
            m_mode = md; m_st = 2; m_elapsed = 0;
        end else if (m_st == 0 && coin) begin
            m_coins++;
            if (m_coins >= CR) m_st = 1;
        end
    endtask

    task automatic compare_all();
        check("state", 32'(o_state), 32'(1 << m_st));
        check("rem_sec", 32'(o_rem_sec), 32'(exp_rem()));
        check("done", 32'(o_done), 32'(m_done));
        check("mode", 32'(o_mode), 32'(m_mode));
        check("paused", 32'(o_paused), 32'(LID_EN && cur_lid && (m_st >= 2)));
    endtask

    task automatic cycle(input bit coin, input bit start, input bit cancel, input int md, input bit lid);
        i_coin = coin; i_start = start; i_cancel = cancel; i_mode = 2'(md); i_lid_open = lid;
        cur_lid = lid;
        @(posedge i_clk);
        model_step(coin, start, cancel, md, lid);
        #1;
        compare_all();
    endtask

    task automatic noise(input int cancel_pm, input bit lid_rand);
        bit lid;
        if (lid_rand && lid_left == 0 && $urandom_range(199) == 0) lid_left = $urandom_range(40, 1);
        lid = (lid_left > 0);
        if (lid_left > 0) lid_left--;
        cycle(1'($urandom), 1'($urandom), $urandom_range(999) < cancel_pm,
              int'($urandom_range(3)), lid);
    endtask

    task automatic arm_and_start(input int md);
        cycle(1'b1, 1'b0, 1'b0, md, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, md, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, md, 1'b0);
    endtask

    task automatic run_to_idle(input int budget, input int cancel_pm, input bit lid_rand);
        int n = 0;
        while (m_st != 0 && n < budget) begin
            noise(cancel_pm, lid_rand);
            n++;
        end
        lid_left = 0;
        check("idle_within_budget", 32'(m_st), 32'd0);
    endtask

    task automatic run_to(input int st, input int rem, input int budget);
        int n = 0;
        while (!(m_st == st && exp_rem() == rem) && n < budget) begin
            cycle(1'b0, 1'b0, 1'b0, int'($urandom_range(3)), 1'b0);
            n++;
        end
        check("reach_target", 32'(m_st == st && exp_rem() == rem), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int soak_cycles;
        model_reset();
        #12;
        compare_all();
        i_rst_n = 1'b1;

        // Coin counting: one coin stays IDLE, start ignored, second coin reaches READY.
        cycle(1'b1, 1'b0, 1'b0, 0, 1'b0);
        repeat (3) cycle(1'b0, 1'b1, 1'b0, 0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 0, 1'b0);
        repeat (5) cycle(1'b1, 1'b0, 1'b0, 0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 0, 1'b0);
        check("soak_load_60", 32'(o_rem_sec), 32'd60);
        run_to_idle(1000, 0, 1'b0);

        // Mode 2 SOAK of 3 minutes, then cancel mid-WASH at 30 s.
        arm_and_start(2);
        cycle(1'b0, 1'b0, 1'b0, 0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1, 1'b0);
        check("soak_cycle2_179", 32'(o_rem_sec), 32'd179);
        run_to(3, 30, 2000);
        cycle(1'b0, 1'b0, 1'b1, 0, 1'b0);
        check("cancel_rem_zero", 32'(o_rem_sec), 32'd0);

        // Single coin holds IDLE; cancel wins over start in READY.
        cycle(1'b1, 1'b0, 1'b0, 0, 1'b0);
        repeat (4) cycle(1'b0, 1'b0, 1'b0, 0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 0, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 3, 1'b0);
        repeat (2) cycle(1'b0, 1'b1, 1'b0, 3, 1'b0);

        // Zero-length RINSE (mode 1) and zero SOAK/SPIN (mode 3) with mode churn.
        arm_and_start(1);
        run_to_idle(2000, 0, 1'b0);
        arm_and_start(3);
        run_to_idle(2000, 0, 1'b0);

        // Lid held open 50 cycles mid-SOAK.
        arm_and_start(0);
        soak_cycles = 1;
        for (int i = 0; i < 400 && m_st == 2; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 1, (i >= 30 && i < 80));
            if (o_state == 6'b000100) soak_cycles++;
        end
        check("soak_len_lid", 32'(soak_cycles), 32'(120 + (LID_EN ? 50 : 0)));
        run_to_idle(1000, 0, 1'b0);

        // Random episodes with lid bursts and occasional cancels.
        for (int e = 0; e < 6; e++) begin
            arm_and_start(int'($urandom_range(3)));
            run_to_idle(3000, 2, 1'b1);
        end

        // Asynchronous reset in the middle of SPIN.
        arm_and_start(0);
        run_to(5, 40, 2000);
        #2;
        i_rst_n = 1'b0;
        #1;
        check("rst_state", 32'(o_state), 32'd1);
        check("rst_mode", 32'(o_mode), 32'd0);
        check("rst_rem", 32'(o_rem_sec), 32'd0);
        check("rst_done", 32'(o_done), 32'd0);
        check("rst_paused", 32'(o_paused), 32'd0);
        model_reset();
        @(negedge i_clk);
        i_rst_n = 1'b1;
        arm_and_start(2);
        run_to_idle(2000, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/wash_ctrl_param.md
Name: wash_ctrl_param

Overview:
- Parametrised second-generation laundry-cycle controller: IDLE -> READY -> SOAK -> WASH -> RINSE -> SPIN -> IDLE.
- Phase durations come from per-mode parameter tables, not hard-coded compares.
- One shared prescaled seconds-down-counter replaces per-phase counters.
- Sits between the coin/keypad front panel and the motor/valve drivers; drives one-hot state, remaining time and a completion pulse.

Parameters:
- TICKS_PER_SEC, 250, i_clk cycles per second; >=1.
- MIN_W, 8, width of one duration entry in minutes.
- SOAK_MIN, {8'd5,8'd3,8'd15,8'd5}, packed 4xMIN_W soak minutes; entry k = bits [k*MIN_W +: MIN_W] for mode k.
- WASH_MIN, {8'd10,8'd8,8'd20,8'd10}, wash minutes per mode, same packing.
- RINSE_MIN, {8'd5,8'd3,8'd15,8'd5}, rinse minutes per mode, same packing.
- SPIN_MIN, {8'd5,8'd3,8'd15,8'd5}, spin minutes per mode, same packing.
- COINS_REQ, 1, coins needed to leave IDLE; 1..15.
- REM_W (localparam), MIN_W+6, width of the remaining-seconds counter.

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  asynchronous active-low reset
- i_coin  in  1  coin strobe; each high cycle counts one coin
- i_start  in  1  start request, sampled in READY
- i_cancel  in  1  abort to IDLE
- i_mode  in  2  0 daily, 1 heavy, 2 delicate, 3 smooth
- i_lid_open  in  1  lid sensor; used only with LID_PAUSE_EN
- o_state  out  6  one-hot: bit0 IDLE, 1 READY, 2 SOAK, 3 WASH, 4 RINSE, 5 SPIN
- o_mode  out  2  mode latched at start
- o_rem_sec  out  REM_W  seconds left in current phase
- o_done  out  1  one-cycle completion pulse
- o_paused  out  1  timer frozen

Behaviour:
- Async reset (i_rst_n low): o_state=6'b000001, o_mode=0, o_rem_sec=0, o_done=0, o_paused=0, coin count=0, prescaler=0.
- Priority each edge: i_cancel > phase completion > i_start > i_coin.
- i_cancel high in any state -> IDLE next edge; coin count, o_rem_sec and prescaler cleared; no o_done.
- IDLE: each i_coin cycle increments the coin count, saturating at COINS_REQ. Reaching COINS_REQ moves to READY next edge. Coins outside IDLE are ignored.
- READY: i_start=1 latches i_mode into o_mode, enters SOAK, and loads o_rem_sec = SOAK_MIN[o_mode]*60 and prescaler=0, all on the same edge. The FSM waits in READY indefinitely.
- Phase timing:
  - The prescaler counts 0..TICKS_PER_SEC-1 and wraps; the wrap cycle is the second strobe.
  - On a strobe, o_rem_sec decrements.
  - A strobe with o_rem_sec==1 ends the phase: next edge enters the following phase with its duration loaded and prescaler=0.
  - A phase of N minutes therefore occupies exactly N*60*TICKS_PER_SEC cycles.
- Zero-duration phase: o_rem_sec loads 0, the phase occupies exactly 1 cycle, then advances.
- SPIN completion -> IDLE, o_done=1 for exactly that one cycle (registered, concurrent with IDLE entry), coin count 0.
- Width: product MIN*60 is computed in REM_W bits with no truncation.
- i_mode changes after start have no effect on the current cycle.
- i_start outside READY is ignored.
- Reset asserted mid-phase -> immediate IDLE with reset values; no partial resume.

Optional Feature:
- Macro LID_PAUSE_EN.
- Defined: while i_lid_open=1 in SOAK..SPIN, the prescaler and o_rem_sec hold and o_paused=1 (combinational from state and lid). The count resumes from the held prescaler value when the lid closes. i_cancel still aborts. i_start in READY is blocked while the lid is open.
- Undefined: i_lid_open ignored, o_paused tied 0.

Test Plan:
- TICKS_PER_SEC=2, COINS_REQ=2, all minutes=1, mode 0: two coin strobes -> READY on the 2nd; start -> SOAK with o_rem_sec=60. Each phase lasts exactly 120 cycles. o_done pulses one cycle at SPIN exit, o_state=000001.
- Mode 2 with SOAK_MIN entry=3: SOAK lasts 360 cycles, and o_rem_sec reads 179 at cycle 2 after entry.
- i_cancel during WASH at o_rem_sec=30 -> IDLE next edge, o_rem_sec=0, no o_done. One coin only (COINS_REQ=2) keeps IDLE.
- i_cancel and i_start in the same READY cycle -> IDLE. i_mode changed mid-WASH -> o_mode unchanged, durations unchanged.
- RINSE entry=0 -> RINSE visible for exactly 1 cycle, then SPIN loaded.
- LID_PAUSE_EN: lid open 50 cycles mid-SOAK -> o_paused=1, o_rem_sec frozen, SOAK lengthened by exactly 50 cycles. Without the macro, lid has no effect.
- Reset pulse mid-SPIN -> all outputs at reset values asynchronously.
